// File: rtl/gnr_ctrl_pkg.sv
// Shared definitions for the attractor-search controller: FSM encoding and
// default widths for the node state vector and the step/period counters.
package gnr_ctrl_pkg;

  localparam int N_NODES_DEF = 8;
  localparam int STEP_W_DEF  = 12;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    STEP_A,
    STEP_B,
    CMP,
    PSTEP,
    PCMP,
    OUT,
    FIN
  } state_t;

endpackage

// File: rtl/gnr_sat_counter.sv
// Saturating up-counter with synchronous clear; at_max flags the ceiling so
// the controller can give up instead of letting the count wrap.
module gnr_sat_counter
  import gnr_ctrl_pkg::*;
#(
  parameter int STEP_W = STEP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              inc,
  output logic [STEP_W-1:0] count,
  output logic              at_max
);

  localparam logic [STEP_W-1:0] CNT_MAX = '1;

  // Count register: clear wins over increment, increment stops at the ceiling.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign at_max = (count == CNT_MAX);

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// Attractor sweep controller for a bank of Boolean network nodes. For each
// initial state it runs Floyd cycle detection: the tortoise (s0) advances one
// step per STEP_A/STEP_B pair while the hare (s1) advances two; after they
// meet, the hare alone is stepped to measure the attractor period.
module gnr_attractor_ctrl
  import gnr_ctrl_pkg::*;
#(
  parameter int N_NODES = N_NODES_DEF,
  parameter int STEP_W  = STEP_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [N_NODES-1:0] init_base,
  input  logic [N_NODES:0]   num_inits,
  output logic               reset_nos,
  output logic               start_s0,
  output logic               start_s1,
  output logic [N_NODES-1:0] init_state,
  input  logic [N_NODES-1:0] s0_vec,
  input  logic [N_NODES-1:0] s1_vec,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [N_NODES-1:0] res_init,
  output logic [STEP_W-1:0]  res_meet,
  output logic [STEP_W-1:0]  res_period,
  output logic               res_timeout,
  output logic               busy,
  output logic               done
);

  localparam logic [STEP_W-1:0]  CNT_LAST = {{(STEP_W-1){1'b1}}, 1'b0};
  localparam logic [N_NODES:0]   REM_ONE  = (N_NODES+1)'(1);

  state_t             state, state_nxt;
  logic [N_NODES-1:0] cur_init;
  logic [N_NODES:0]   remaining;
  logic               timeout;

  logic [STEP_W-1:0]  meet_cnt, per_cnt;
  logic               meet_at_max, per_at_max;
  logic               nodes_eq, meet_hit;

  assign nodes_eq = (s0_vec == s1_vec);
  // The meet counter is bumped in CMP, so the limit is hit when this
  // increment lands on the ceiling.
  assign meet_hit = meet_at_max || (meet_cnt == CNT_LAST);

  gnr_sat_counter #(.STEP_W(STEP_W)) u_meet_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == LOAD),
    .inc    (state == CMP),
    .count  (meet_cnt),
    .at_max (meet_at_max)
  );

  gnr_sat_counter #(.STEP_W(STEP_W)) u_per_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == LOAD),
    .inc    (state == PSTEP),
    .count  (per_cnt),
    .at_max (per_at_max)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Sweep bookkeeping: current initial state, results left, timeout flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_init  <= '0;
      remaining <= '0;
      timeout   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cur_init  <= init_base;
          remaining <= num_inits;
        end
        LOAD: timeout <= 1'b0;
        CMP:  if (!nodes_eq && meet_hit) timeout <= 1'b1;
        PCMP: if (!nodes_eq && per_at_max) timeout <= 1'b1;
        OUT:  if (res_ready) begin
          remaining <= remaining - 1'b1;
          cur_init  <= cur_init + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_inits == '0) ? FIN : LOAD;
      LOAD:    state_nxt = STEP_A;
      STEP_A:  state_nxt = STEP_B;
      STEP_B:  state_nxt = CMP;
      CMP:     if (nodes_eq)      state_nxt = PSTEP;
               else if (meet_hit) state_nxt = OUT;
               else               state_nxt = STEP_A;
      PSTEP:   state_nxt = PCMP;
      PCMP:    if (nodes_eq || per_at_max) state_nxt = OUT;
               else                        state_nxt = PSTEP;
      OUT:     if (res_ready) state_nxt = (remaining > REM_ONE) ? LOAD : FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore outputs; everything reads zero in IDLE.
  always_comb begin
    reset_nos   = 1'b0;
    start_s0    = 1'b0;
    start_s1    = 1'b0;
    init_state  = '0;
    res_valid   = 1'b0;
    res_init    = '0;
    res_meet    = '0;
    res_period  = '0;
    res_timeout = 1'b0;
    busy        = (state != IDLE);
    done        = 1'b0;
    case (state)
      LOAD: begin
        reset_nos  = 1'b1;
        init_state = cur_init;
      end
      STEP_A, STEP_B: begin
        start_s0 = 1'b1;
        start_s1 = 1'b1;
      end
      PSTEP: start_s1 = 1'b1;
      OUT: begin
        res_valid   = 1'b1;
        res_init    = cur_init;
        res_meet    = meet_cnt;
        res_period  = per_cnt;
        res_timeout = timeout;
      end
      FIN:     done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// Bench for gnr_attractor_ctrl with a 4-node behavioural node bank and a
// reference model that finds meet/period by iterating the next-state map.
`timescale 1ns/1ps
module tb_gnr_attractor_ctrl;

  localparam int N    = 4;
  localparam int SW   = 3;
  localparam int MAXC = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          res_ready = 1'b0;
  logic [N-1:0]  init_base = '0;
  logic [N:0]    num_inits = '0;
  logic          reset_nos, start_s0, start_s1, res_valid, res_timeout, busy, done;
  logic [N-1:0]  init_state, s0_vec, s1_vec, res_init;
  logic [SW-1:0] res_meet, res_period;

  int n_pass = 0;
  int n_total = 0;

  int           fmode = 0;
  logic [N-1:0] lut [16];
  logic [N-1:0] nb_s0 = '0;
  logic [N-1:0] nb_s1 = '0;
  logic         nb_phase = 1'b0;

  int strobe_cnt = 0;
  int done_cnt = 0;
  int valid_cnt = 0;
  int bad_overlap = 0;
  int bad_idle = 0;

  gnr_attractor_ctrl #(.N_NODES(N), .STEP_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init_base(init_base), .num_inits(num_inits),
    .reset_nos(reset_nos), .start_s0(start_s0), .start_s1(start_s1), .init_state(init_state),
    .s0_vec(s0_vec), .s1_vec(s1_vec), .res_valid(res_valid), .res_ready(res_ready),
    .res_init(res_init), .res_meet(res_meet), .res_period(res_period),
    .res_timeout(res_timeout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] fnext(input logic [N-1:0] x);
    case (fmode)
      0:       return x;
      1:       return {x[N-2:0], x[N-1]};
      2:       return x + 1'b1;
      default: return lut[x];
    endcase
  endfunction

  function automatic logic [N-1:0] fiter(input logic [N-1:0] x, input int n);
    logic [N-1:0] y = x;
    for (int i = 0; i < n; i++) y = fnext(y);
    return y;
  endfunction

  // Reference: tortoise position k vs hare 2k, then hare-only period search.
  task automatic ref_model(input logic [N-1:0] x, output logic [SW-1:0] meet,
                           output logic [SW-1:0] period, output logic tout);
    int m = 0;
    int p = 0;
    for (int k = 1; k <= MAXC && m == 0; k++)
      if (fiter(x, k) == fiter(x, 2 * k)) m = k;
    if (m == 0) begin
      meet = SW'(MAXC); period = '0; tout = 1'b1;
    end else begin
      for (int q = 1; q <= MAXC && p == 0; q++)
        if (fiter(x, 2 * m + q) == fiter(x, m)) p = q;
      meet = SW'(m);
      period = (p == 0) ? SW'(MAXC) : SW'(p);
      tout = (p == 0);
    end
  endtask

  // Behavioural node bank: hare steps on every strobe, tortoise on every second.
  always @(posedge clk) begin
    if (reset_nos) begin
      nb_s0 <= init_state; nb_s1 <= init_state; nb_phase <= 1'b0;
    end else begin
      if (start_s1) nb_s1 <= fnext(nb_s1);
      if (start_s0) begin
        nb_phase <= ~nb_phase;
        if (nb_phase) nb_s0 <= fnext(nb_s0);
      end
    end
  end
  assign s0_vec = nb_s0;
  assign s1_vec = nb_s1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (reset_nos && (start_s0 || start_s1)) bad_overlap <= bad_overlap + 1;
      if (!busy && (reset_nos || start_s0 || start_s1 || res_valid || done)) bad_idle <= bad_idle + 1;
    end
    if (start_s0 || start_s1) strobe_cnt <= strobe_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (res_valid) valid_cnt <= valid_cnt + 1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start(input logic [N-1:0] base, input int n);
    init_base = base; num_inits = (N+1)'(n); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int cyc, output bit ok);
    cyc = 0; ok = 0;
    while (cyc < 200 && !ok) begin
      if (res_valid) ok = 1;
      else begin tick(); cyc++; end
    end
  endtask

  task automatic wait_done(output bit ok);
    int c = 0;
    ok = 0;
    while (c < 50 && !ok) begin
      if (done) ok = 1;
      else begin tick(); c++; end
    end
  endtask

  task automatic accept();
    res_ready = 1'b1; tick(); res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(); tick();
    n_total++; if ({busy, res_valid, done, reset_nos, start_s0, start_s1, res_timeout} !== 7'b0)
      $display("FAIL reset_ctrl: got %b expected 0000000", {busy, res_valid, done, reset_nos, start_s0, start_s1, res_timeout}); else n_pass++;
    n_total++; if ({init_state, res_init, res_meet, res_period} !== '0)
      $display("FAIL reset_data: got %h expected 0", {init_state, res_init, res_meet, res_period}); else n_pass++;
    rst_n = 1'b1; tick();
  endtask

  task automatic test_identity();
    int cyc; bit ok;
    fmode = 0;
    pulse_start(4'h5, 1);
    n_total++; if ({busy, reset_nos, init_state} !== {2'b11, 4'h5})
      $display("FAIL id_load: got %b expected 110101", {busy, reset_nos, init_state}); else n_pass++;
    wait_valid(cyc, ok);
    n_total++; if (!ok || cyc != 6) $display("FAIL id_latency: got %0d expected 6", cyc); else n_pass++;
    n_total++; if ({res_init, res_meet, res_period, res_timeout} !== {4'h5, 3'd1, 3'd1, 1'b0})
      $display("FAIL id_result: got init=%h meet=%0d per=%0d to=%b expected 5/1/1/0", res_init, res_meet, res_period, res_timeout); else n_pass++;
    accept();
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL id_done: got no done expected done"); else n_pass++;
    tick();
    n_total++; if ({busy, done} !== 2'b00) $display("FAIL id_idle: got %b expected 00", {busy, done}); else n_pass++;
  endtask

  task automatic test_rotate();
    int cyc; bit ok;
    fmode = 1;
    pulse_start(4'b0001, 1);
    wait_valid(cyc, ok);
    n_total++; if (!ok || cyc != 21) $display("FAIL rot_latency: got %0d expected 21", cyc); else n_pass++;
    n_total++; if ({res_meet, res_period, res_timeout} !== {3'd4, 3'd4, 1'b0})
      $display("FAIL rot_result: got meet=%0d per=%0d to=%b expected 4/4/0", res_meet, res_period, res_timeout); else n_pass++;
    accept(); wait_done(ok); tick();
  endtask

  task automatic test_timeout();
    int cyc; bit ok;
    fmode = 2;
    pulse_start(4'($urandom_range(0, 15)), 1);
    wait_valid(cyc, ok);
    n_total++; if (!ok || cyc != 22) $display("FAIL to_latency: got %0d expected 22", cyc); else n_pass++;
    n_total++; if ({res_meet, res_period, res_timeout} !== {3'd7, 3'd0, 1'b1})
      $display("FAIL to_result: got meet=%0d per=%0d to=%b expected 7/0/1", res_meet, res_period, res_timeout); else n_pass++;
    accept(); wait_done(ok); tick();
  endtask

  task automatic test_zero_inits();
    int s0 = strobe_cnt;
    int v0 = valid_cnt;
    int d0 = done_cnt;
    pulse_start(4'h3, 0);
    n_total++; if ({done, busy} !== 2'b11) $display("FAIL zero_done: got %b expected 11", {done, busy}); else n_pass++;
    tick();
    n_total++; if ({done, busy} !== 2'b00) $display("FAIL zero_end: got %b expected 00", {done, busy}); else n_pass++;
    tick();
    n_total++; if (strobe_cnt != s0 || valid_cnt != v0 || done_cnt != d0 + 1)
      $display("FAIL zero_activity: got strobes=%0d valids=%0d dones=%0d expected 0/0/1", strobe_cnt - s0, valid_cnt - v0, done_cnt - d0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int cyc; bit ok; int d0;
    fmode = 0;
    d0 = done_cnt;
    pulse_start(4'hF, 2);
    wait_valid(cyc, ok);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++; if ({res_valid, res_init, res_meet, res_period, res_timeout} !== {1'b1, 4'hF, 3'd1, 3'd1, 1'b0})
        $display("FAIL b2b_hold%0d: got v=%b init=%h meet=%0d per=%0d expected 1/f/1/1", i, res_valid, res_init, res_meet, res_period); else n_pass++;
    end
    accept();
    n_total++; if ({reset_nos, init_state, done_cnt - d0} !== {1'b1, 4'h0, 32'd0})
      $display("FAIL b2b_reload: got rn=%b init=%h dones=%0d expected 1/0/0", reset_nos, init_state, done_cnt - d0); else n_pass++;
    wait_valid(cyc, ok);
    n_total++; if (!ok || {res_init, res_meet, res_period, res_timeout} !== {4'h0, 3'd1, 3'd1, 1'b0})
      $display("FAIL b2b_second: got init=%h meet=%0d per=%0d expected 0/1/1", res_init, res_meet, res_period); else n_pass++;
    accept();
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL b2b_done: got no done expected done"); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid();
    int c = 0; int cyc; bit ok;
    fmode = 1;
    pulse_start(4'b0001, 1);
    while (c < 100 && !(start_s1 && !start_s0)) begin tick(); c++; end
    n_total++; if (c >= 100) $display("FAIL rmid_pstep: got none expected PSTEP"); else n_pass++;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    n_total++; if ({busy, res_valid, start_s1, reset_nos} !== 4'b0000)
      $display("FAIL rmid_idle: got %b expected 0000", {busy, res_valid, start_s1, reset_nos}); else n_pass++;
    tick();
    fmode = 0;
    pulse_start(4'h9, 1);
    wait_valid(cyc, ok);
    n_total++; if (!ok || {res_init, res_meet, res_period, res_timeout} !== {4'h9, 3'd1, 3'd1, 1'b0})
      $display("FAIL rmid_restart: got init=%h meet=%0d per=%0d to=%b expected 9/1/1/0", res_init, res_meet, res_period, res_timeout); else n_pass++;
    accept(); wait_done(ok); tick();
  endtask

  task automatic test_random();
    int cyc; bit ok; int n; int dly;
    logic [N-1:0] base, x;
    logic [SW-1:0] em, ep; logic et;
    fmode = 3;
    for (int it = 0; it < 8; it++) begin
      for (int j = 0; j < 16; j++) lut[j] = 4'($urandom_range(0, 15));
      base = 4'($urandom_range(0, 15));
      n = $urandom_range(1, 3);
      pulse_start(base, n);
      for (int r = 0; r < n; r++) begin
        x = base + 4'(r);
        ref_model(x, em, ep, et);
        wait_valid(cyc, ok);
        n_total++; if (!ok || {res_init, res_meet, res_period, res_timeout} !== {x, em, ep, et})
          $display("FAIL rnd%0d_%0d: got init=%h meet=%0d per=%0d to=%b expected %h/%0d/%0d/%b",
                   it, r, res_init, res_meet, res_period, res_timeout, x, em, ep, et); else n_pass++;
        n_total++; if (cyc != 3 * int'(em) + 2 * int'(ep) + 1)
          $display("FAIL rnd%0d_%0d_latency: got %0d expected %0d", it, r, cyc, 3 * int'(em) + 2 * int'(ep) + 1); else n_pass++;
        dly = $urandom_range(0, 3);
        for (int d = 0; d < dly; d++) tick();
        accept();
      end
      wait_done(ok);
      n_total++; if (!ok) $display("FAIL rnd%0d_done: got no done expected done", it); else n_pass++;
      tick();
    end
  endtask

  task automatic test_invariants();
    n_total++; if (bad_overlap != 0 || bad_idle != 0)
      $display("FAIL strobe_rules: got overlap=%0d idle=%0d expected 0/0", bad_overlap, bad_idle); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_rotate();
    test_timeout();
    test_zero_inits();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
